// File: rtl/operand_if.sv
// Operand-entry bus: the board side drives switches and buttons, and the
// adder side reads the captured operands and status.
interface operand_if;
    logic [8:0] sw;
    logic       btn_load;
    logic       btn_clear;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       op_valid;
    logic       load_pulse;
    logic       busy;

    // Stimulus/board side
    modport master (
        output sw, btn_load, btn_clear,
        input  a, b, cin, op_valid, load_pulse, busy
    );

    // Operand-entry block side
    modport slave (
        input  sw, btn_load, btn_clear,
        output a, b, cin, op_valid, load_pulse, busy
    );
endinterface

// File: rtl/operand_entry.sv
// Operand entry: synchronizes the board switches and buttons, debounces the
// load button with a four-state FSM, and captures {cin, b, a} from the
// switches once per clean press. The clear button zeroes the captured operands.
// Optional build macro OPERAND_TMR_EN keeps a, b, cin and op_valid in three
// register copies and drives the outputs from a bitwise 2-of-3 vote.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    operand_if.slave io
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS, HOLD, RELEASE} state_e;

    typedef struct packed {
        logic       valid;
        logic       cin;
        logic [3:0] b;
        logic [3:0] a;
    } opnd_t;

    // Synchronizer chain: bit 10 = clear, bit 9 = load, bits 8:0 = switches.
    logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
    logic [10:0] sync_s;
    logic [8:0]  sw_s;
    logic        load_s;
    logic        clear_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;
    logic             load_pulse_q, load_pulse_d;
    logic             busy_q, busy_d;
    opnd_t            opnd;
    opnd_t            opnd_d;

    // Shift the raw asynchronous inputs one stage down the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], {io.btn_clear, io.btn_load, io.sw}};
    end

    // Synchronizer flops.
    // NOTE: every flop here uses <= so all stages update from pre-edge values;
    // a blocking = would collapse the chain into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign sw_s    = sync_s[8:0];
    assign load_s  = sync_s[9];
    assign clear_s = sync_s[10];

    // Debounce FSM next-state logic; the counter restarts on every state entry.
    // NOTE: each variable gets its hold value first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_s) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!load_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!load_s) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (load_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand update and registered strobes; clear beats a same-cycle capture.
    always_comb begin
        opnd_d = opnd;
        if (clear_s) begin
            opnd_d = '0;
        end else if (capture) begin
            opnd_d = '{valid: 1'b1, cin: sw_s[8], b: sw_s[7:4], a: sw_s[3:0]};
        end
        load_pulse_d = capture & ~clear_s;
        busy_d       = (state_d != IDLE);
    end

    // FSM state, debounce counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_pulse_q <= load_pulse_d;
            busy_q       <= busy_d;
        end
    end

`ifdef OPERAND_TMR_EN
    opnd_t opnd0_q, opnd1_q, opnd2_q;

    // Three operand copies, always written, cleared and reset together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd0_q <= '0;
            opnd1_q <= '0;
            opnd2_q <= '0;
        end else begin
            opnd0_q <= opnd_d;
            opnd1_q <= opnd_d;
            opnd2_q <= opnd_d;
        end
    end

    assign opnd = opnd_t'((opnd0_q & opnd1_q) | (opnd1_q & opnd2_q) | (opnd0_q & opnd2_q));
`else
    opnd_t opnd_q;

    // Single operand copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) opnd_q <= '0;
        else     opnd_q <= opnd_d;
    end

    assign opnd = opnd_q;
`endif

    assign io.a          = opnd.a;
    assign io.b          = opnd.b;
    assign io.cin        = opnd.cin;
    assign io.op_valid   = opnd.valid;
    assign io.load_pulse = load_pulse_q;
    assign io.busy       = busy_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Expected captures are queued when a press is driven and compared when
// load_pulse appears; any pulse with nothing queued is flagged.
module tb_operand_entry;

    localparam int DC = 4;
    localparam int SS = 2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   pulse_cnt;
    int   base;
    exp_t exp_q[$];

    operand_if intf ();

    operand_entry #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
        .clk (clk),
        .rst (rst),
        .io  (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                              input logic ecin, input logic evalid);
        check({tag, "_a"},     32'(intf.a),        32'(ea));
        check({tag, "_b"},     32'(intf.b),        32'(eb));
        check({tag, "_cin"},   32'(intf.cin),      32'(ecin));
        check({tag, "_valid"}, 32'(intf.op_valid), 32'(evalid));
    endtask

    // Advance n clock cycles; returns at the falling edge for sampling/driving.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Scoreboard consumer: every load_pulse must match the oldest queued press.
    always @(negedge clk) begin
        if (intf.load_pulse === 1'b1) begin
            exp_t e;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_outs("capture", e.a, e.b, e.cin, 1'b1);
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        pulse_cnt = 0;
        rst             = 1'b1;
        intf.sw         = '0;
        intf.btn_load   = 1'b0;
        intf.btn_clear  = 1'b0;

        // Reset state
        @(negedge clk);
        check_outs("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        check("reset_lp",   32'(intf.load_pulse), 32'd0);
        check("reset_busy", 32'(intf.busy),       32'd0);
        rst = 1'b0;
        step(2);

        // Clean press: pulse after edge SS+1+DC = 7
        base          = pulse_cnt;
        intf.sw       = 9'h1_A5;
        intf.btn_load = 1'b1;
        exp_q.push_back('{a: 4'h5, b: 4'hA, cin: 1'b1});
        step(6);
        check("press_lp_early", 32'(intf.load_pulse), 32'd0);
        check("press_busy",     32'(intf.busy),       32'd1);
        check_outs("press_pre", 4'h0, 4'h0, 1'b0, 1'b0);
        step(1);
        check("press_lp_edge7", 32'(intf.load_pulse), 32'd1);
        step(1);
        check("press_lp_once", 32'(intf.load_pulse), 32'd0);
        intf.sw = 9'h0_FF;
        step(6);
        check_outs("hold_sw_change", 4'h5, 4'hA, 1'b1, 1'b1);
        check("hold_one_pulse", 32'(pulse_cnt - base), 32'd1);

        // Release debounce: busy stays high through edge 6, falls after edge 7
        intf.btn_load = 1'b0;
        step(6);
        check("release_busy_hi", 32'(intf.busy), 32'd1);
        step(1);
        check("release_busy_lo", 32'(intf.busy), 32'd0);
        check_outs("after_release", 4'h5, 4'hA, 1'b1, 1'b1);

        // Glitch: 3-cycle press is rejected
        base          = pulse_cnt;
        intf.sw       = 9'h1_11;
        intf.btn_load = 1'b1;
        step(3);
        intf.btn_load = 1'b0;
        step(1);
        check("glitch_busy_mid", 32'(intf.busy), 32'd1);
        step(9);
        check("glitch_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("glitch_idle",     32'(intf.busy),         32'd0);
        check_outs("glitch_keep", 4'h5, 4'hA, 1'b1, 1'b1);

        // Press, then release bounce 0-1-0 -> single capture
        base          = pulse_cnt;
        intf.sw       = 9'h0_C3;
        intf.btn_load = 1'b1;
        exp_q.push_back('{a: 4'h3, b: 4'hC, cin: 1'b0});
        step(10);
        intf.btn_load = 1'b0;
        step(2);
        intf.btn_load = 1'b1;
        step(2);
        intf.btn_load = 1'b0;
        step(2);
        check("bounce_busy_hi", 32'(intf.busy), 32'd1);
        step(12);
        check("bounce_one_pulse", 32'(pulse_cnt - base), 32'd1);
        check("bounce_busy_lo",   32'(intf.busy),         32'd0);
        check_outs("bounce_keep", 4'h3, 4'hC, 1'b0, 1'b1);

        // Clear coinciding with capture edge 7: clear wins, no pulse
        base          = pulse_cnt;
        intf.sw       = 9'h1_FF;
        intf.btn_load = 1'b1;
        step(4);
        intf.btn_clear = 1'b1;
        step(1);
        intf.btn_clear = 1'b0;
        step(1);
        check_outs("clr_pre", 4'h3, 4'hC, 1'b0, 1'b1);
        step(1);
        check_outs("clr_cap", 4'h0, 4'h0, 1'b0, 1'b0);
        check("clr_no_lp", 32'(intf.load_pulse), 32'd0);
        check("clr_busy",  32'(intf.busy),       32'd1);
        intf.btn_load = 1'b0;
        step(12);
        check("clr_no_pulse", 32'(pulse_cnt - base), 32'd0);
        check("clr_idle",     32'(intf.busy),         32'd0);

        // Next full press after clear
        intf.sw       = 9'h0_33;
        intf.btn_load = 1'b1;
        exp_q.push_back('{a: 4'h3, b: 4'h3, cin: 1'b0});
        step(7);
        check("reload_lp", 32'(intf.load_pulse), 32'd1);
        intf.btn_load = 1'b0;
        step(12);
        check_outs("reload_keep", 4'h3, 4'h3, 1'b0, 1'b1);

        // Reset mid-PRESS aborts; held button is a fresh press afterwards
        base          = pulse_cnt;
        intf.sw       = 9'h1_A5;
        intf.btn_load = 1'b1;
        step(4);
        check("rst_pre_busy", 32'(intf.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_outs("rst_async", 4'h0, 4'h0, 1'b0, 1'b0);
        check("rst_async_busy", 32'(intf.busy),       32'd0);
        check("rst_async_lp",   32'(intf.load_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('{a: 4'h5, b: 4'hA, cin: 1'b1});
        step(6);
        check("rst_lp_early", 32'(intf.load_pulse), 32'd0);
        check_outs("rst_no_cap", 4'h0, 4'h0, 1'b0, 1'b0);
        step(1);
        check("rst_lp_edge7", 32'(intf.load_pulse), 32'd1);
        step(2);
        check("rst_one_pulse", 32'(pulse_cnt - base), 32'd1);

`ifdef OPERAND_TMR_EN
        // One corrupted copy is outvoted
        force dut.opnd0_q = '0;
        step(1);
        check_outs("tmr_vote", 4'h5, 4'hA, 1'b1, 1'b1);
        release dut.opnd0_q;
        step(1);
`endif

        intf.btn_load = 1'b0;
        step(12);
        check("final_idle",        32'(intf.busy),   32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
